// File: rtl/sync_fifo_fwft.sv
// Synchronous single-clock FIFO with programmable almost-full/empty thresholds,
// sticky overflow/underflow flags and a selectable registered or FWFT read port.
module sync_fifo_fwft #(
    parameter int P_DEPTH  = 8,
    parameter int P_DATA_W = 8,
    parameter int P_FWFT   = 0,
    parameter int P_AF_TH  = P_DEPTH - 2,
    parameter int P_AE_TH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       w_en,
    input  logic [P_DATA_W-1:0]        i_data,
    output logic                       o_full,
    output logic                       o_afull,
    input  logic                       r_en,
    output logic [P_DATA_W-1:0]        o_data,
    output logic                       o_empty,
    output logic                       o_aempty,
    output logic [$clog2(P_DEPTH):0]   o_count,
    output logic                       o_ovf,
    output logic                       o_udf
);

    localparam int LP_AW = $clog2(P_DEPTH);
    localparam int LP_CW = LP_AW + 1;
    localparam logic [LP_CW-1:0] LP_FULL = LP_CW'(P_DEPTH);
    localparam logic [LP_CW-1:0] LP_AF   = LP_CW'(P_AF_TH);
    localparam logic [LP_CW-1:0] LP_AE   = LP_CW'(P_AE_TH);

    logic [P_DATA_W-1:0] r_mem [P_DEPTH];
    logic [LP_AW-1:0]    r_wrPtr;
    logic [LP_AW-1:0]    r_rdPtr;
    logic [LP_CW-1:0]    r_count;
    logic                r_ovf;
    logic                r_udf;
    logic                w_wrAccept;
    logic                w_rdAccept;

    // Flags come straight off the registered count, so acceptance only ever
    // sees the state from the start of the cycle.
    assign o_full   = (r_count == LP_FULL);
    assign o_empty  = (r_count == '0);
    assign o_afull  = (r_count >= LP_AF);
    assign o_aempty = (r_count <= LP_AE);
    assign o_count  = r_count;
    assign o_ovf    = r_ovf;
    assign o_udf    = r_udf;

    assign w_wrAccept = w_en && !o_full;
    assign w_rdAccept = r_en && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (w_wrAccept) begin
                r_wrPtr <= r_wrPtr + LP_AW'(1);
            end
            if (w_rdAccept) begin
                r_rdPtr <= r_rdPtr + LP_AW'(1);
            end
            case ({w_wrAccept, w_rdAccept})
                2'b10:   r_count <= r_count + LP_CW'(1);
                2'b01:   r_count <= r_count - LP_CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_en && o_full) begin
                r_ovf <= 1'b1;
            end
            if (r_en && o_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    // Storage is never cleared; a reset simply makes its contents unreachable.
    always_ff @(posedge clk) begin
        if (!rst && w_wrAccept) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    generate
        if (P_FWFT != 0) begin : g_fwft
            assign o_data = r_mem[r_rdPtr];
        end else begin : g_std
            logic [P_DATA_W-1:0] r_dataOut;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dataOut <= '0;
                end else if (w_rdAccept) begin
                    r_dataOut <= r_mem[r_rdPtr];
                end
            end

            assign o_data = r_dataOut;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Drives a standard-read and an FWFT instance with identical stimulus and
// compares both against a queue-based reference model every cycle.
module tb_sync_fifo_fwft;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int AF_TH = 6;
    localparam int AE_TH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          w_en;
    logic          r_en;
    logic [DW-1:0] i_data;

    logic          fullS, afullS, emptyS, aemptyS, ovfS, udfS;
    logic [DW-1:0] dataS;
    logic [3:0]    countS;
    logic          fullF, afullF, emptyF, aemptyF, ovfF, udfF;
    logic [DW-1:0] dataF;
    logic [3:0]    countF;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [DW-1:0] modelQ[$];
    logic [DW-1:0] modelData;
    logic          modelOvf;
    logic          modelUdf;

    always #5 clk = ~clk;

    sync_fifo_fwft #(.P_DEPTH(DEPTH), .P_DATA_W(DW), .P_FWFT(0),
                     .P_AF_TH(AF_TH), .P_AE_TH(AE_TH)) dutStd (
        .clk(clk), .rst(rst), .w_en(w_en), .i_data(i_data),
        .o_full(fullS), .o_afull(afullS), .r_en(r_en), .o_data(dataS),
        .o_empty(emptyS), .o_aempty(aemptyS), .o_count(countS),
        .o_ovf(ovfS), .o_udf(udfS)
    );

    sync_fifo_fwft #(.P_DEPTH(DEPTH), .P_DATA_W(DW), .P_FWFT(1),
                     .P_AF_TH(AF_TH), .P_AE_TH(AE_TH)) dutFwft (
        .clk(clk), .rst(rst), .w_en(w_en), .i_data(i_data),
        .o_full(fullF), .o_afull(afullF), .r_en(r_en), .o_data(dataF),
        .o_empty(emptyF), .o_aempty(aemptyF), .o_count(countF),
        .o_ovf(ovfF), .o_udf(udfF)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Reference model: a FIFO is a queue; flags are arithmetic on its size.
    task automatic updateModel(input logic rstIn, input logic wIn, input logic rIn,
                               input logic [DW-1:0] dIn);
        int  size;
        logic wasFull, wasEmpty;
        size     = modelQ.size();
        wasFull  = (size == DEPTH);
        wasEmpty = (size == 0);
        if (rstIn) begin
            modelQ.delete();
            modelData = '0;
            modelOvf  = 1'b0;
            modelUdf  = 1'b0;
        end else begin
            if (wIn && wasFull)  modelOvf = 1'b1;
            if (rIn && wasEmpty) modelUdf = 1'b1;
            if (rIn && !wasEmpty) modelData = modelQ.pop_front();
            if (wIn && !wasFull)  modelQ.push_back(dIn);
        end
    endtask

    task automatic checkAll();
        int size;
        size = modelQ.size();
        checkOutput("countStd",  32'(countS),  32'(size));
        checkOutput("countFwft", 32'(countF),  32'(size));
        checkOutput("empty",     32'(emptyS),  32'(size == 0));
        checkOutput("full",      32'(fullS),   32'(size == DEPTH));
        checkOutput("afull",     32'(afullS),  32'(size >= AF_TH));
        checkOutput("aempty",    32'(aemptyS), 32'(size <= AE_TH));
        checkOutput("emptyFwft", 32'(emptyF),  32'(size == 0));
        checkOutput("ovf",       32'(ovfS),    32'(modelOvf));
        checkOutput("udf",       32'(udfS),    32'(modelUdf));
        checkOutput("ovfFwft",   32'(ovfF),    32'(modelOvf));
        checkOutput("udfFwft",   32'(udfF),    32'(modelUdf));
        checkOutput("dataStd",   32'(dataS),   32'(modelData));
        if (size != 0) begin
            checkOutput("dataFwft", 32'(dataF), 32'(modelQ[0]));
        end
    endtask

    // One clock cycle: drive inputs, let the edge happen, then check #1 later.
    task automatic applyStimulus(input logic rstIn, input logic wIn, input logic rIn,
                                 input logic [DW-1:0] dIn);
        rst    = rstIn;
        w_en   = wIn;
        r_en   = rIn;
        i_data = dIn;
        @(posedge clk);
        updateModel(rstIn, wIn, rIn, dIn);
        #1;
        checkAll();
    endtask

    initial begin
        rst = 1'b1; w_en = 1'b0; r_en = 1'b0; i_data = '0;
        modelData = '0; modelOvf = 1'b0; modelUdf = 1'b0;
        #2;
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hEE);

        // Fill 0x10..0x17, then drain, then hammer both ends.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h99);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h18);
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h42);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h50 + i));
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h60);
        checkOutput("count4Hold", 32'(countS), 32'd4);

        // FWFT: single word falls through without a read.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hA5);
        checkOutput("fwftA5", 32'(dataF), 32'hA5);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("fwftEmpty", 32'(emptyF), 32'd1);

        // Alternating write/read across several pointer wraps.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h80 + i));
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
            checkOutput("wrapData", 32'(dataS), 32'(8'h80 + i));
        end

        // Reset at count 5 discards entries; next write lands at pointer 0.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF);
        checkOutput("midRstCount", 32'(countS), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h3C);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("midRstData", 32'(dataS), 32'h3C);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 99) == 0),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/sync_fifo_fwft.md
SYNC_FIFO_FWFT -- requirements
Module: sync_fifo_fwft

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter P_DEPTH, default 8, SHALL set the number of entries; it must be a power of two and at least 2.
REQ-003 Parameter P_DATA_W, default 8, SHALL set the data width in bits.
REQ-004 Parameter P_FWFT, default 0, SHALL select the read mode: 0 = standard registered read, 1 = first-word-fall-through.
REQ-005 Parameter P_AF_TH, default P_DEPTH-2, SHALL set the almost-full threshold in entries.
REQ-006 Parameter P_AE_TH, default 2, SHALL set the almost-empty threshold in entries.
REQ-007 Port list, one per line:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- w_en  in  1  write request.
- i_data  in  P_DATA_W  write data.
- o_full  out  1  FIFO holds P_DEPTH entries.
- o_afull  out  1  almost full.
- r_en  in  1  read request.
- o_data  out  P_DATA_W  read data.
- o_empty  out  1  FIFO holds 0 entries.
- o_aempty  out  1  almost empty.
- o_count  out  log2(P_DEPTH)+1  current fill level.
- o_ovf  out  1  sticky overflow flag.
- o_udf  out  1  sticky underflow flag.

Function
REQ-008 A write SHALL be accepted when w_en=1 and o_full=0, both sampled at the same clk edge; i_data is stored at the write pointer.
REQ-009 A read SHALL be accepted when r_en=1 and o_empty=0, both sampled at the same clk edge.
REQ-010 Acceptance SHALL use only the flag values registered at the start of the cycle.
- Write while full SHALL be rejected, even if a read is accepted in the same cycle.
- Read while empty SHALL be rejected, even if a write is accepted in the same cycle.
REQ-011 Write and read pointers SHALL be log2(P_DEPTH) bits wide.
- Each advances by 1 per accepted operation.
- Each wraps from P_DEPTH-1 to 0.
REQ-012 o_count SHALL update on the edge after each cycle as follows:
- +1 on accept-write only.
- -1 on accept-read only.
- Unchanged on both or neither.
- Never below 0 or above P_DEPTH.
REQ-013 The status flags SHALL be decoded from registered o_count with no added latency:
- o_full = (o_count == P_DEPTH).
- o_empty = (o_count == 0).
- o_afull = (o_count >= P_AF_TH).
- o_aempty = (o_count <= P_AE_TH).
REQ-014 With P_FWFT=0, o_data SHALL be a register loaded with the head entry on the edge that accepts a read.
- The value is visible the cycle after r_en.
- o_data holds its value otherwise.
REQ-015 With P_FWFT=1, o_data SHALL present the head entry whenever o_empty=0.
- After a write into an empty FIFO, o_empty falls and o_data is valid one cycle after the write edge.
- An accepted read shows the next entry in the following cycle.
- o_data is don't-care while o_empty=1.
REQ-016 o_ovf SHALL set on any edge with w_en=1 and o_full=1, and hold until reset.
REQ-017 o_udf SHALL set on any edge with r_en=1 and o_empty=1, and hold until reset.
REQ-018 Rejected operations SHALL NOT alter pointers, o_count, storage or o_data.
REQ-019 Data SHALL leave in exactly write order across any number of pointer wraps.

Reset
REQ-020 On the first clk edge with rst=1, the block SHALL clear pointers, o_count, o_ovf, o_udf and, when P_FWFT=0, o_data to 0.
- Resulting outputs: o_empty=1, o_aempty=1, o_full=0, o_afull=0.
- Storage contents need not be cleared.
REQ-021 While rst=1, w_en and r_en SHALL be ignored.
REQ-022 Reset asserted mid-operation SHALL discard all stored entries; the first write after reset lands at pointer 0.

Verification (P_DEPTH=8, P_DATA_W=8, P_AF_TH=6, P_AE_TH=2)
REQ-023 Fill/drain, P_FWFT=0: write 0x10..0x17 -> o_full=1 and o_count=8; then read 8 times -> o_data=0x10..0x17, each one cycle after its r_en, and o_empty=1 after the last.
REQ-024 Thresholds: write 2 -> o_aempty=1; 3rd write -> o_aempty=0; 6th write -> o_afull=1; 8th write -> o_full=1.
REQ-025 Simultaneous operations:
- At count 8, w_en=1 and r_en=1 -> read accepted, write rejected, count=7, o_ovf=1.
- At count 0, both -> write accepted, count=1, o_udf=1.
- At count 4, both -> count stays 4.
REQ-026 FWFT, P_FWFT=1: write 0xA5 into empty FIFO -> next cycle o_empty=0 and o_data=0xA5 with no r_en; after r_en -> o_empty=1.
REQ-027 Wrap: 20 cycles of alternating write/read with an incrementing pattern -> all 20 values returned in order; o_ovf=0 and o_udf=0.
REQ-028 Mid-operation reset: at count 5, pulse rst for 1 cycle -> o_count=0, o_empty=1, flags clear; next write 0x3C followed by a read -> 0x3C returned.
